// File: rtl/dp_pkg.sv
// Shared types and encodings for the sequenced datapath.
// Build option DP_CARRY_EN adds a carry flag, widening status to {C,V,N,Z}.
package dp_pkg;

    typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_e;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_IMM   = 2'b01;
    localparam logic [1:0] WB_MDATA = 2'b10;
    localparam logic [1:0] WB_PC    = 2'b11;

`ifdef DP_CARRY_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif

endpackage

// File: rtl/datapath_seq_if.sv
// Command channel of the sequenced datapath: valid/ready handshake plus the
// operation fields and side operands captured on accept.
interface datapath_seq_if #(
    parameter int W     = 16,
    parameter int RW    = 3,
    parameter int IMM_W = 8,
    parameter int PC_W  = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [RW-1:0]    cmd_rn;
    logic [RW-1:0]    cmd_rm;
    logic [RW-1:0]    cmd_rd;
    logic [1:0]       cmd_shift;
    logic [1:0]       cmd_aluop;
    logic             cmd_asel;
    logic             cmd_bsel;
    logic [1:0]       cmd_wbsel;
    logic             cmd_wb_en;
    logic             cmd_s_en;
    logic [IMM_W-1:0] imm;
    logic [W-1:0]     mdata;
    logic [PC_W-1:0]  pc;

    modport master (
        output cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_aluop,
               cmd_asel, cmd_bsel, cmd_wbsel, cmd_wb_en, cmd_s_en,
               imm, mdata, pc,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_aluop,
               cmd_asel, cmd_bsel, cmd_wbsel, cmd_wb_en, cmd_s_en,
               imm, mdata, pc,
        output cmd_ready
    );
endinterface

// File: rtl/dp_alu.sv
// Combinational ALU: result plus flags {V,N,Z}, or {C,V,N,Z} when DP_CARRY_EN
// is defined (C = carry out of ADD, A>=B unsigned for SUB).
module dp_alu
    import dp_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [1:0]    op,
    output logic [W-1:0]  result,
    output logic [SW-1:0] flags
);

    logic v;

    // NOTE: combinational logic uses blocking '=' and assigns every output
    // before the case, so no path can hold a stale value and infer a latch.
    always_comb begin
        result = '0;
        v      = 1'b0;
        case (op)
            ALU_ADD: begin
                result = a + b;
                v      = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result = a - b;
                v      = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_AND: result = a & b;
            default: result = ~b;
        endcase
    end

`ifdef DP_CARRY_EN
    logic c;

    // A wrapped sum smaller than an addend means the add carried out.
    always_comb begin
        c = 1'b0;
        case (op)
            ALU_ADD: c = (result < a);
            ALU_SUB: c = (a >= b);
            default: c = 1'b0;
        endcase
    end

    assign flags = {c, v, result[W-1], result == '0};
`else
    assign flags = {v, result[W-1], result == '0};
`endif

endmodule

// File: rtl/datapath_seq.sv
// Register-file datapath driven by a five-state micro-sequencer; one accepted
// command runs IDLE->RDA->RDB->EXEC->WB. DP_CARRY_EN adds the C status flag.
module datapath_seq
    import dp_pkg::*;
#(
    parameter  int W     = 16,
    parameter  int NREG  = 8,
    parameter  int IMM_W = 8,
    parameter  int PC_W  = 8,
    localparam int RW    = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    datapath_seq_if.slave cmd,
    output logic          done,
    output logic [W-1:0]  dp_out,
    output logic [SW-1:0] status,
    input  logic [RW-1:0] dbg_rnum,
    output logic [W-1:0]  dbg_rdata
);

    state_e           state;
    logic [W-1:0]     regs [NREG];

    logic [RW-1:0]    rn_q, rm_q, rd_q;
    logic [1:0]       shift_q, aluop_q, wbsel_q;
    logic             asel_q, bsel_q, wb_en_q, s_en_q;
    logic [IMM_W-1:0] imm_q;
    logic [W-1:0]     mdata_q;
    logic [PC_W-1:0]  pc_q;

    logic [W-1:0]     a_q, b_q;
    logic [W-1:0]     b_shift, a_in, b_in, imm_ext, wb_data, alu_result;
    logic [SW-1:0]    alu_flags;

    assign cmd.cmd_ready = (state == IDLE);
    assign dbg_rdata     = regs[dbg_rnum];
    assign imm_ext       = W'($signed(imm_q));

    always_comb begin
        b_shift = b_q;
        case (shift_q)
            SH_LSL1: b_shift = b_q << 1;
            SH_LSR1: b_shift = b_q >> 1;
            SH_ASR1: b_shift = $signed(b_q) >>> 1;
            default: b_shift = b_q;
        endcase
    end

    assign a_in = asel_q ? '0 : a_q;
    assign b_in = bsel_q ? imm_ext : b_shift;

    dp_alu #(.W(W)) u_alu (
        .a      (a_in),
        .b      (b_in),
        .op     (aluop_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // The ALU source is C as registered in EXEC, one cycle before writeback.
    always_comb begin
        wb_data = dp_out;
        case (wbsel_q)
            WB_IMM:   wb_data = imm_ext;
            WB_MDATA: wb_data = mdata_q;
            WB_PC:    wb_data = W'(pc_q);
            default:  wb_data = dp_out;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values. The register file is small and flop-based, so it is
    // cleared by reset like the rest of the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            done    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            dp_out  <= '0;
            status  <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
            shift_q <= '0;
            aluop_q <= '0;
            wbsel_q <= '0;
            asel_q  <= 1'b0;
            bsel_q  <= 1'b0;
            wb_en_q <= 1'b0;
            s_en_q  <= 1'b0;
            imm_q   <= '0;
            mdata_q <= '0;
            pc_q    <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        rn_q    <= cmd.cmd_rn;
                        rm_q    <= cmd.cmd_rm;
                        rd_q    <= cmd.cmd_rd;
                        shift_q <= cmd.cmd_shift;
                        aluop_q <= cmd.cmd_aluop;
                        wbsel_q <= cmd.cmd_wbsel;
                        asel_q  <= cmd.cmd_asel;
                        bsel_q  <= cmd.cmd_bsel;
                        wb_en_q <= cmd.cmd_wb_en;
                        s_en_q  <= cmd.cmd_s_en;
                        imm_q   <= cmd.imm;
                        mdata_q <= cmd.mdata;
                        pc_q    <= cmd.pc;
                        state   <= RDA;
                    end
                end
                RDA: begin
                    a_q   <= regs[rn_q];
                    state <= RDB;
                end
                RDB: begin
                    b_q   <= regs[rm_q];
                    state <= EXEC;
                end
                EXEC: begin
                    dp_out <= alu_result;
                    if (s_en_q) status <= alu_flags;
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    if (wb_en_q) regs[rd_q] <= wb_data;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised successor to the team's 16-bit, 8-register datapath.
- Adds an internal micro-sequencer, so the controller issues one command per operation with a valid/ready handshake instead of driving per-cycle load enables.
- Width, register count, immediate width and PC width are generic; reset clears all state.
- Sits between the CPU control FSM and memory/PC logic.

Parameters:
- W, 16, datapath and register width.
- NREG, 8, number of registers (power of two, >=2); RW = clog2(NREG).
- IMM_W, 8, immediate field width; sign-extended to W.
- PC_W, 8, PC width; zero-extended to W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_rn  in  RW  A-operand register.
- cmd_rm  in  RW  B-operand register.
- cmd_rd  in  RW  destination register.
- cmd_shift  in  2  B shift: 00 none, 01 lsl1, 10 lsr1, 11 asr1.
- cmd_aluop  in  2  00 ADD, 01 SUB, 10 AND, 11 NOT B.
- cmd_asel  in  1  1 forces A operand to zero.
- cmd_bsel  in  1  1 selects sign-extended immediate as B operand.
- cmd_wbsel  in  2  writeback source: 00 ALU, 01 imm, 10 mdata, 11 PC.
- cmd_wb_en  in  1  write result to rd.
- cmd_s_en  in  1  update status.
- imm  in  IMM_W  immediate.
- mdata  in  W  memory data.
- pc  in  PC_W  program counter.
- done  out  1  one-cycle pulse in writeback cycle.
- dp_out  out  W  C register.
- status  out  SW  {V,N,Z}, or {C,V,N,Z} with DP_CARRY_EN.
- dbg_rnum  in  RW  debug read address.
- dbg_rdata  out  W  combinational read of R[dbg_rnum].

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all registers, A, B, C and status cleared to 0, done=0, cmd_ready=1 after the reset cycle. Reset mid-operation aborts the operation; no writeback occurs.
- State machine: IDLE -> RDA -> RDB -> EXEC -> WB -> IDLE.
- cmd_ready = (state==IDLE). Accept occurs when cmd_valid && cmd_ready at a clock edge. On accept, all cmd_* fields, imm, mdata and pc are latched; later changes to these inputs are ignored.
- RDA: A <= R[rn].
- RDB: B <= R[rm].
- EXEC:
  - Operands: Ain = asel ? 0 : A. Bin = bsel ? sext(imm) : shift(B).
  - C <= ALU(Ain, Bin), computed mod 2^W.
  - If s_en: Z = (result==0); N = result[W-1]; V = signed overflow for ADD/SUB, 0 for AND/NOT.
  - Status holds when s_en=0.
- WB:
  - If wb_en: R[rd] <= wbsel source. ALU source uses the new C value, i.e. the value registered in EXEC.
  - done=1; next state is IDLE.
- Latency and throughput: accept edge to done is 4 cycles; throughput is one command per 5 cycles. Latency is fixed regardless of wbsel.
- Hazards: rd equal to rn or rm is legal because operands are read before writeback. A command back-to-back after done observes the updated register.
- Debug read: dbg_rdata reflects a write on the edge following WB.
- dp_out and status change only in EXEC or on reset.

Optional Feature:
- Macro DP_CARRY_EN.
- Defined: SW=4 and status[3]=C, where C is the carry out of ADD and NOT-borrow of SUB (A>=B unsigned) for SUB, and 0 for AND/NOT. C updates under s_en.
- Undefined: SW=3; no carry logic is present.

Decomposition:
- Package dp_pkg holds:
  - state enum: IDLE, RDA, RDB, EXEC, WB.
  - ALU op constants.
  - shift code constants.
  - wbsel constants.
- Natural sub-module: dp_alu, parametrised by W. It is combinational and computes result, Z, N, V and C.
- The register file stays inline.

Test Plan:
- Reset, then read every register via dbg_rnum -> all registers = 0, status = 0, cmd_ready = 1.
- Write R0 = 7 and R1 = 2 via wbsel=imm. Then run ADD R2 = R0 + (R1 lsl1) with s_en -> done pulses 4 cycles after accept, R2 = 11, dp_out = 11, status = 000.
- SUB R3 = R1 - R0 with s_en -> R3 = 0xFFFB, N=1, Z=0, V=0. With DP_CARRY_EN, C=0.
- ADD of 0x7FFF + 1 (imm) -> 0x8000 with V=1, N=1. Then SUB of equal values -> Z=1 (C=1 if enabled).
- Assert reset during EXEC of a command to R4 -> no writeback, R4 stays 0, state returns to IDLE.
- Hold cmd_valid=1 continuously -> accepts only when idle, one op per 5 cycles, inputs changed after accept have no effect.
